// File: rtl/bram_stream_reader_pkg.sv
// Shared definitions for the BRAM port-B stream reader: FSM encoding and
// the address/data widths shared with bram_mux.
package bram_stream_reader_pkg;

  localparam int unsigned BRAM_ADDR_W = 9;
  localparam int unsigned BRAM_DATA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/bram_stream_reader_fifo.sv
// Synchronous FIFO with occupancy count; head word is presented combinationally.
module stream_fifo_sync
  import bram_stream_reader_pkg::*;
#(
  parameter int unsigned WIDTH = BRAM_DATA_W + 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_push = push_i && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/bram_stream_reader.sv
// Takes the shared BRAM port B, sweeps a burst of words from base_addr and
// re-emits them as a valid/ready stream tagged with m_last.
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int unsigned ADDR_W     = BRAM_ADDR_W,
  parameter int unsigned DATA_W     = BRAM_DATA_W,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic              sel,
  output logic [ADDR_W-1:0] addrb,
  output logic              enb,
  input  logic [DATA_W-1:0] doutb,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);

  localparam int unsigned LW = ADDR_W + 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OW = CW + 1;

  state_e            state_q, state_d;
  logic              sel_q, sel_d;
  logic [ADDR_W-1:0] base_q;
  logic [LW-1:0]     len_q;
  logic [LW-1:0]     issued_q;
  logic [LW-1:0]     accepted_q;
  logic [RD_LAT-1:0] pipe_vld_q, pipe_vld_d;
  logic [RD_LAT-1:0] pipe_last_q, pipe_last_d;
  logic [CW-1:0]     fifo_count;
  logic [CW-1:0]     inflight;
  logic [OW-1:0]     occupancy;
  logic              credit_ok;
  logic              issue_last;
  logic              accept_last;
  logic              fifo_empty;
  logic              pop;
  logic [DATA_W:0]   fifo_rdata;

  assign issue_last  = (issued_q == len_q - LW'(1));
  assign accept_last = (accepted_q == len_q - LW'(1));

  // Credit counts FIFO words plus reads still in the BRAM pipe, before any pop.
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < RD_LAT; i++) begin
      inflight = inflight + CW'(pipe_vld_q[i]);
    end
    occupancy = {1'b0, fifo_count} + {1'b0, inflight};
    credit_ok = (occupancy < OW'(FIFO_DEPTH));
  end

  assign enb   = (state_q == S_ISSUE) && (issued_q < len_q) && credit_ok;
  assign addrb = base_q + issued_q[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = (length != '0) ? S_ISSUE : S_DONE;
      S_ISSUE: if (enb && issue_last) state_d = S_DRAIN;
      S_DRAIN: if (pop && accept_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q != S_IDLE);
    done  = (state_q == S_DONE);
    sel_d = (state_d == S_ISSUE) || (state_d == S_DRAIN);
  end

  assign sel = sel_q;

  always_comb begin
    pipe_vld_d     = '0;
    pipe_last_d    = '0;
    pipe_vld_d[0]  = enb;
    pipe_last_d[0] = enb && issue_last;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_last_d[i] = pipe_last_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q       <= 1'b0;
      base_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      accepted_q  <= '0;
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
    end else begin
      sel_q       <= sel_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_last_q <= pipe_last_d;
      if (state_q == S_IDLE && start) begin
        base_q     <= base_addr;
        len_q      <= length;
        issued_q   <= '0;
        accepted_q <= '0;
      end else begin
        if (enb) issued_q   <= issued_q + LW'(1);
        if (pop) accepted_q <= accepted_q + LW'(1);
      end
    end
  end

  stream_fifo_sync #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (pipe_vld_q[RD_LAT-1]),
    .wdata_i ({pipe_last_q[RD_LAT-1], doutb}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign m_valid = !fifo_empty;
  assign pop     = m_valid && m_ready;
  assign m_data  = m_valid ? fifo_rdata[DATA_W-1:0] : '0;
  assign m_last  = m_valid && fifo_rdata[DATA_W];

endmodule

// File: tb/tb_bram_stream_reader.sv
// Scoreboard bench: three readers (RD_LAT 1/2/3) share stimulus, each with its
// own BRAM model; a single monitor checks every lane against queued expectations.
module tb_bram_stream_reader;

  localparam int NL = 3;

  typedef struct packed {
    logic        is_done;
    logic        full_rate;
    logic        zero_len;
    logic        last;
    logic [31:0] data;
    logic [31:0] start_cyc;
  } exp_t;

  function automatic int lane_depth(input int g);
    return (g == 2) ? 8 : 4;
  endfunction

  function automatic logic [31:0] bram_word(input logic [8:0] a);
    return {7'h2B, a, 7'h55, ~a};
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start;
  logic       m_ready;
  logic [8:0] base_addr;
  logic [9:0] length;

  logic        sel_w     [NL];
  logic        enb_w     [NL];
  logic        busy_w    [NL];
  logic        done_w    [NL];
  logic        m_valid_w [NL];
  logic        m_last_w  [NL];
  logic [8:0]  addrb_w   [NL];
  logic [31:0] m_data_w  [NL];

  exp_t       exp_q [NL][$];
  logic [8:0] adr_q [NL][$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int done_seen = 0;
  int done_target = 0;
  int to_req = 0;
  int rdy_mode = 0;

  for (genvar g = 0; g < NL; g++) begin : lane
    localparam int unsigned RDL = g + 1;
    localparam int unsigned DEP = lane_depth(g);
    logic [31:0] rd_pipe [RDL];
    logic [31:0] doutb_l;

    always @(posedge clk) begin
      rd_pipe[0] <= enb_w[g] ? bram_word(addrb_w[g]) : 32'hDEAD_BEEF;
      for (int k = 1; k < int'(RDL); k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign doutb_l = rd_pipe[RDL-1];

    bram_stream_reader #(
      .ADDR_W     (9),
      .DATA_W     (32),
      .RD_LAT     (RDL),
      .FIFO_DEPTH (DEP)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .length    (length),
      .busy      (busy_w[g]),
      .done      (done_w[g]),
      .sel       (sel_w[g]),
      .addrb     (addrb_w[g]),
      .enb       (enb_w[g]),
      .doutb     (doutb_l),
      .m_data    (m_data_w[g]),
      .m_valid   (m_valid_w[g]),
      .m_ready   (m_ready),
      .m_last    (m_last_w[g])
    );
  end

  task automatic chk(input int g, input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL lane%0d(RD_LAT=%0d) %s: got %h, expected %h at cycle %0d", g, g + 1, name, act, req, cyc);
    end
  endtask

  // Monitor: all comparisons happen here, on the falling edge.
  initial begin : monitor
    logic        rst_d1;
    int          to_seen;
    logic        stall_prev [NL];
    logic [32:0] held       [NL];
    logic        seen_enb   [NL];
    logic        seen_valid [NL];
    int          first_enb  [NL];
    int          last_hs    [NL];
    int          outst      [NL];
    int          hist       [NL];
    exp_t        e;
    rst_d1  = 1'b0;
    to_seen = 0;
    for (int g = 0; g < NL; g++) begin
      stall_prev[g] = 1'b0; held[g] = '0; seen_enb[g] = 1'b0; seen_valid[g] = 1'b0;
      first_enb[g] = 0; last_hs[g] = 0; outst[g] = 0; hist[g] = 0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      if (to_req != to_seen) begin
        chk(0, "done_timeout", 64'(to_req), 64'(to_seen));
        to_seen = to_req;
      end
      for (int g = 0; g < NL; g++) begin
        if (rst_d1) begin
          chk(g, "reset_outputs",
              64'({sel_w[g], enb_w[g], busy_w[g], done_w[g], m_valid_w[g], m_last_w[g], addrb_w[g], m_data_w[g]}),
              64'(0));
          exp_q[g].delete();
          adr_q[g].delete();
          stall_prev[g] = 1'b0; seen_enb[g] = 1'b0; seen_valid[g] = 1'b0;
          outst[g] = 0; hist[g] = 0;
        end else begin
          if (hist[g] != 0) chk(g, "sel_while_inflight", 64'(sel_w[g]), 64'(1));
          if (enb_w[g] === 1'b1) begin
            chk(g, "enb_owns_port", 64'({busy_w[g], sel_w[g]}), 64'(2'b11));
            chk(g, "credit_limit", 64'(outst[g] < lane_depth(g)), 64'(1));
            chk(g, "enb_expected", 64'(adr_q[g].size() != 0), 64'(1));
            if (adr_q[g].size() != 0) chk(g, "addrb", 64'(addrb_w[g]), 64'(adr_q[g].pop_front()));
            if (!seen_enb[g]) begin
              seen_enb[g] = 1'b1;
              first_enb[g] = cyc;
            end
            outst[g]++;
          end
          if (m_valid_w[g] === 1'b1 && !seen_valid[g] && seen_enb[g]) begin
            seen_valid[g] = 1'b1;
            chk(g, "first_valid_latency", 64'(cyc - first_enb[g]), 64'(g + 2));
          end
          if (stall_prev[g])
            chk(g, "hold_under_stall", 64'({m_valid_w[g], m_last_w[g], m_data_w[g]}), 64'({1'b1, held[g]}));
          if (m_valid_w[g] === 1'b1 && m_ready) begin
            chk(g, "word_expected", 64'(exp_q[g].size() != 0 && !exp_q[g][0].is_done), 64'(1));
            if (exp_q[g].size() != 0 && !exp_q[g][0].is_done) begin
              e = exp_q[g].pop_front();
              chk(g, "word", 64'({m_last_w[g], m_data_w[g]}), 64'({e.last, e.data}));
            end
            outst[g]--;
            last_hs[g] = cyc;
          end
          if (done_w[g] === 1'b1) begin
            chk(g, "done_expected", 64'(exp_q[g].size() != 0 && exp_q[g][0].is_done), 64'(1));
            if (exp_q[g].size() != 0 && exp_q[g][0].is_done) begin
              e = exp_q[g].pop_front();
              chk(g, "all_reads_issued", 64'(adr_q[g].size()), 64'(0));
              chk(g, "sel_released_at_done", 64'(sel_w[g]), 64'(0));
              if (e.zero_len) begin
                chk(g, "zero_len_done_cycle", 64'(cyc), 64'(e.start_cyc + 1));
                chk(g, "zero_len_no_reads", 64'(seen_enb[g]), 64'(0));
              end else begin
                chk(g, "done_after_last_hs", 64'(cyc), 64'(last_hs[g] + 1));
                if (e.full_rate)
                  chk(g, "full_rate_duration", 64'(cyc - first_enb[g]), 64'(int'(e.data) + g + 2));
              end
            end
            done_seen++;
            seen_enb[g] = 1'b0;
            seen_valid[g] = 1'b0;
          end
          hist[g] = ((hist[g] << 1) | int'(enb_w[g] === 1'b1)) & ((1 << (g + 1)) - 1);
          stall_prev[g] = (m_valid_w[g] === 1'b1) && !m_ready;
          held[g] = {m_last_w[g], m_data_w[g]};
        end
      end
      rst_d1 = rst;
    end
  end

  initial begin : ready_drv
    int k;
    k = 0;
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      k++;
      m_ready = (rdy_mode == 0) ? 1'b1 : ((k % 3) == 0);
    end
  end

  task automatic issue(input int b, input int n, input logic full);
    exp_t       e;
    logic [8:0] a;
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = 9'(b);
    length    = 10'(n);
    for (int g = 0; g < NL; g++) begin
      for (int i = 0; i < n; i++) begin
        a = 9'(b + i);
        adr_q[g].push_back(a);
        e = '0;
        e.data = bram_word(a);
        e.last = (i == n - 1);
        exp_q[g].push_back(e);
      end
      e = '0;
      e.is_done   = 1'b1;
      e.full_rate = full;
      e.zero_len  = (n == 0);
      e.data      = 32'(n);
      e.start_cyc = 32'(cyc + 1);
      exp_q[g].push_back(e);
    end
    done_target = done_seen + NL;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget && done_seen < done_target; k++) @(posedge clk);
    if (done_seen < done_target) begin
      $display("FAIL done_wait: %0d done pulses seen, %0d required", done_seen, done_target);
      to_req++;
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin : stim
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    length = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    issue(0, 8, 1'b1);      wait_done(100);
    issue(510, 4, 1'b1);    wait_done(100);
    rdy_mode = 1;
    issue(100, 16, 1'b0);   wait_done(300);
    rdy_mode = 0;
    issue(7, 0, 1'b1);      wait_done(50);
    issue(37, 512, 1'b1);   wait_done(1500);

    // Reset lands mid-burst; queued expectations are flushed by the monitor.
    issue(200, 10, 1'b1);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    issue(300, 5, 1'b1);    wait_done(100);

    // Second start while busy must not produce reads, words or a done.
    issue(50, 12, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = 9'd400;
    length = 10'd3;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(200);
    repeat (12) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
